// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : Load/store initiator for a 4 KiB word-organised, byte-enabled,
//             registered-read data memory. One request at a time; stores
//             answer one edge after accept, loads two edges after accept.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module lsu_ctrl #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        err_q, err_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        err_c;
  logic [3:0]  we_c;
  logic [31:0] din_c;
  logic [31:0] sh_c;
  logic [31:0] load_c;

  // Decode the incoming request: error conditions, byte-lane mask, replicated data
  always_comb begin
    err_c = 1'b0;
    we_c  = 4'b0000;
    din_c = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (req_addr[0]) err_c = 1'b1;
      3'b010:         if (req_addr[1:0] != 2'b00) err_c = 1'b1;
      default:        err_c = 1'b1;
    endcase
    if (req_is_store && req_funct3[2]) err_c = 1'b1;
    if (req_addr >= 32'(ADDR_LIMIT)) err_c = 1'b1;
    case (req_funct3[1:0])
      2'b00: begin
        we_c  = 4'b0001 << req_addr[1:0];
        din_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        we_c  = 4'b0011 << req_addr[1:0];
        din_c = {2{req_wdata[15:0]}};
      end
      default: begin
        we_c  = 4'b1111;
        din_c = req_wdata;
      end
    endcase
    // Loads and rejected requests never drive byte enables.
    if (!req_is_store || err_c) we_c = 4'b0000;
  end

  // Align the returned word to the addressed byte and extend to 32 bits
  always_comb begin
    sh_c = mem_dout >> {mem_addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_c = {{24{sh_c[7]}}, sh_c[7:0]};
      3'b100:  load_c = {24'h000000, sh_c[7:0]};
      3'b001:  load_c = {{16{sh_c[15]}}, sh_c[15:0]};
      3'b101:  load_c = {16'h0000, sh_c[15:0]};
      default: load_c = mem_dout;
    endcase
  end

  // Next-state and next-output logic for the IDLE/ACCESS/CAPTURE sequence
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    err_d        = err_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          err_d      = err_c;
          we_d       = we_c;
          mem_addr_d = req_addr;
          mem_din_d  = din_c;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (is_store_q || err_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          resp_rdata_d = 32'h0;
          state_d      = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_c;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and registered outputs, with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      err_q        <= 1'b0;
      we_q         <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_din_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      err_q        <= err_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Write enables are gated by reset directly so an interrupted store cannot write
  assign mem_we     = (rst_n && (state_q == ACCESS)) ? we_q : 4'b0000;
  assign req_ready  = (state_q == IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Directed self-checking bench for lsu_ctrl with a behavioural
//             4 KiB byte-enabled registered-read memory.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_LIMIT(4096)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_dout     (mem_dout)
  );

  // Behavioural memory: byte-enabled write, one-cycle registered read
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
    mem_dout <= mem[mem_addr[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request and collect what the DUT does until its response
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic [3:0] we_acc, output logic [31:0] din_acc,
                         output logic rdy_acc, output logic [3:0] we_late,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output logic rdy_resp);
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    req_valid    = 1'b0;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'h5555_5555;
    we_acc   = mem_we;
    din_acc  = mem_din;
    rdy_acc  = req_ready;
    we_late  = 4'b0000;
    lat      = 0;
    rdata    = 32'hX;
    err      = 1'bX;
    rdy_resp = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      we_late = we_late | mem_we;
      if (resp_valid) begin
        lat      = k;
        rdata    = resp_rdata;
        err      = resp_err;
        rdy_resp = req_ready;
        break;
      end
    end
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_we,
                          input logic [31:0] exp_din);
    logic [3:0] wa, wl; logic [31:0] d, r; logic ra, e, rr; int lat;
    run_req(1'b1, f3, a, wd, wa, d, ra, wl, lat, r, e, rr);
    chk({tag, "_we"}, {28'h0, wa}, {28'h0, exp_we});
    chk({tag, "_din"}, d, exp_din);
    chk({tag, "_we_after"}, {28'h0, wl}, 32'h0);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, {31'h0, e}, 32'h0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_rdata);
    logic [3:0] wa, wl; logic [31:0] d, r; logic ra, e, rr; int lat;
    run_req(1'b0, f3, a, 32'h0, wa, d, ra, wl, lat, r, e, rr);
    chk({tag, "_we"}, {28'h0, wa | wl}, 32'h0);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_rdata"}, r, exp_rdata);
    chk({tag, "_err"}, {31'h0, e}, 32'h0);
  endtask

  task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a);
    logic [3:0] wa, wl; logic [31:0] d, r; logic ra, e, rr; int lat;
    run_req(st, f3, a, 32'h1234_5678, wa, d, ra, wl, lat, r, e, rr);
    chk({tag, "_we"}, {28'h0, wa | wl}, 32'h0);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, {31'h0, e}, 32'h1);
    chk({tag, "_rdata"}, r, 32'h0);
  endtask

  initial begin
    logic [3:0] wa, wl; logic [31:0] d, r; logic ra, e, rr; int lat;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we_low", {28'h0, mem_we}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_we", {28'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);

    // SW 0x10, with handshake/throughput observations
    run_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, wa, d, ra, wl, lat, r, e, rr);
    chk("sw10_we", {28'h0, wa}, 32'hF);
    chk("sw10_din", d, 32'hDEAD_BEEF);
    chk("sw10_ready_busy", {31'h0, ra}, 32'h0);
    chk("sw10_we_after", {28'h0, wl}, 32'h0);
    chk("sw10_lat", lat, 1);
    chk("sw10_err", {31'h0, e}, 32'h0);
    chk("sw10_rdata", r, 32'h0);
    chk("sw10_ready_at_resp", {31'h0, rr}, 32'h1);
    chk("sw10_mem_addr_hold", mem_addr, 32'h10);
    @(negedge clk);
    chk("sw10_pulse_one", {31'h0, resp_valid}, 32'h0);
    do_load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF);

    // Byte store and byte/word loads
    do_store("sb13", 3'b000, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_load("lb13", 3'b000, 32'h13, 32'hFFFF_FFA5);
    do_load("lbu13", 3'b100, 32'h13, 32'h0000_00A5);
    do_load("lw10b", 3'b010, 32'h10, 32'hA5AD_BEEF);
    do_load("lbu11", 3'b100, 32'h11, 32'h0000_00BE);

    // Halfword store and loads
    do_store("sh22", 3'b001, 32'h22, 32'h0000_8001, 4'b1100, 32'h8001_8001);
    do_load("lh22", 3'b001, 32'h22, 32'hFFFF_8001);
    do_load("lhu22", 3'b101, 32'h22, 32'h0000_8001);
    do_load("lh20", 3'b001, 32'h20, 32'h0000_0000);

    // Error cases
    do_err("lw11", 1'b0, 3'b010, 32'h11);
    do_err("sh21", 1'b1, 3'b001, 32'h21);
    do_err("sw1000", 1'b1, 3'b010, 32'h1000);
    do_err("f3_011", 1'b0, 3'b011, 32'h10);
    do_err("sbu", 1'b1, 3'b100, 32'h10);
    do_load("lw10_intact", 3'b010, 32'h10, 32'hA5AD_BEEF);

    // Reset during ACCESS must cancel a store
    do_store("sw30", 3'b010, 32'h30, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_funct3   = 3'b010;
    req_addr     = 32'h30;
    req_wdata    = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rstacc_we", {28'h0, mem_we}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstacc_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rstacc_we_hold", {28'h0, mem_we}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstacc_resp_after", {31'h0, resp_valid}, 32'h0);
    chk("rstacc_ready", {31'h0, req_ready}, 32'h1);
    do_load("lw30", 3'b010, 32'h30, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
